spi_slave_byte_ctrl: RTL and testbench
======================================

// Module: spi_slave_byte_ctrl
// PURPOSE
//  Sequences an SPI slave port, mode 0 (CPOL=0, CPHA=0), MSB first, from the system clock.
//  - Synchronises SCLK/CS_N/MOSI and uses their edges to shift receive and transmit bytes.
//  - Presents bytes to the host through valid/ready handshakes.
//  - Sits between the pad ring and the register-file or host bridge.
// PARAMETERS
//  DATA_W       8  bits per SPI word.
//  SYNC_STAGES  2  synchroniser flops on each SPI input (minimum 2).
// PORTS
//  clk          in   1       system clock; the only clock.
//  rst_n        in   1       synchronous, active-low reset.
//  spi_sclk     in   1       SPI clock, asynchronous to clk.
//  spi_cs_n     in   1       chip select, active low, asynchronous.
//  spi_mosi     in   1       master-out data, asynchronous.
//  spi_miso     out  1       slave-out data.
//  spi_miso_oe  out  1       MISO output enable: 1 while the frame is active.
//  tx_data      in   DATA_W  next byte to transmit.
//  tx_valid     in   1       tx_data is valid.
//  tx_ready     out  1       holding register empty; a transfer happens when tx_valid & tx_ready.
//  rx_data      out  DATA_W  last received byte; stable while rx_valid=1.
//  rx_valid     out  1       received byte pending.
//  rx_ready     in   1       host consumes rx_data when rx_valid & rx_ready.
//  rx_overrun   out  1       1-cycle pulse: byte completed while previous still pending.
//  tx_underrun  out  1       1-cycle pulse: shifter load found the holding register empty.
//  busy         out  1       frame active (synchronised CS_N low).
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE; tx_ready=1; all other outputs 0; shifters, counter
//   and holding register cleared.
//  Input path: each SPI input passes through SYNC_STAGES flops, then a 1-flop edge detector.
//   Edge pulses appear SYNC_STAGES+1 clk cycles after the pin edge.
//   Requirement: SCLK high and SCLK low each last >=4 clk cycles.
//  States:
//   IDLE -> ACTIVE on CS_N fall. Entering ACTIVE:
//    - load the TX shifter, set bit_cnt=0, drive spi_miso=shifter MSB, set spi_miso_oe=1, busy=1.
//   ACTIVE -> IDLE on CS_N rise, from any bit position:
//    - partial RX bits are discarded (no rx_valid); bit_cnt=0; spi_miso_oe=0; busy=0.
//    - the holding register is untouched.
//  In ACTIVE, SCLK rise:
//   - shift mosi into the RX shifter LSB; bit_cnt++.
//   - when bit_cnt reaches DATA_W: copy the RX shifter to rx_data, set rx_valid=1, bit_cnt=0.
//     If rx_valid was already 1 and not being consumed that cycle: pulse rx_overrun;
//     the new byte overwrites rx_data.
//  In ACTIVE, SCLK fall:
//   - if bit_cnt==0 (byte boundary), reload the TX shifter; otherwise shift left and update spi_miso.
//  TX shifter load:
//   - holding register full: take it and clear full (tx_ready=1 next cycle).
//   - holding register empty: load all-zeros and pulse tx_underrun.
//  Holding register:
//   - tx_ready = ~full, registered.
//   - if a load and a tx_valid acceptance fall in the same cycle, the accepted byte wins
//     (full stays 1).
//  rx_valid clears the cycle after rx_valid & rx_ready. If consumption coincides with a new byte
//   completing: rx_valid stays 1, rx_data takes the new byte, no overrun.
//  SCLK edges while in IDLE are ignored.
//  A CS_N rise and an SCLK edge in the same cycle: CS_N wins.
//  Counter width: $clog2(DATA_W+1).
// STRUCTURE
//  spi_defs.vh (shared include):
//   - state encodings IDLE=1'b0, ACTIVE=1'b1.
//   - default DATA_W.
//   - SPI mode localparams for later CPOL/CPHA variants.
//  Sub-module spi_sync_edge, instantiated once per SPI input:
//   - SYNC_STAGES synchroniser plus registered delay.
//   - outputs: synced level, rise pulse, fall pulse.
//  Everything else lives in the top level.
// TESTING
//  1. Reset sequencing:
//     rst_n low 3 cycles with the SPI pins toggling -> tx_ready=1; miso, miso_oe, busy, rx_valid = 0.
//  2. Single frame:
//     host preloads tx 0xA5, then master sends 0x3C (sclk = clk/8) -> MISO bits 1,0,1,0,0,1,0,1;
//     rx_data=0x3C, rx_valid=1; tx_ready=1 after CS fall.
//  3. Back-to-back bytes in one CS frame:
//     tx 0x11, refilled with 0x22 before byte 1 ends; MOSI 0x80, 0x01
//     -> two rx bytes 0x80, 0x01; MISO sequence 0x11, 0x22; no underrun.
//  4. Underrun/overrun:
//     no tx preload, rx_ready=0, two bytes 0xFF, 0x55
//     -> MISO all zeros; tx_underrun pulses twice; rx_overrun pulses once; rx_data=0x55.
//  5. Abort:
//     CS_N rises after 5 SCLK rises -> no rx_valid; busy=0 and miso_oe=0 within SYNC_STAGES+2 cycles;
//     the next full frame receives correctly.
//  6. Simultaneous events:
//     - rx_ready asserted on the same cycle a byte completes -> rx_valid stays 1, no overrun.
//     - rst_n low mid-frame -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/spi_slave_byte_ctrl_pkg.sv
// Shared definitions for the SPI slave byte controller: FSM encoding, default
// geometry and SPI mode identifiers for future CPOL/CPHA variants.
package spi_slave_byte_ctrl_pkg;

  localparam int DATA_W_DEFAULT      = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,  // CPOL=0, CPHA=0 (the only mode implemented here)
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_t;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  function automatic spi_mode_t spi_mode(input logic cpol, input logic cpha);
    return spi_mode_t'({cpol, cpha});
  endfunction

endpackage

// File: rtl/spi_slave_byte_ctrl_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, followed by a one-flop
// delay that yields single-cycle rise/fall pulses in the clk domain.
module spi_slave_byte_ctrl_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Reset to the pin's idle level so leaving reset never fabricates an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments keep every stage sampling the previous
      // value, which is what makes this a shift chain rather than a wire.
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_slave_byte_ctrl.sv
// SPI mode-0 slave, MSB first, oversampled by clk. Bytes move to and from the
// host through valid/ready handshakes with a single TX holding register.
module spi_slave_byte_ctrl
  import spi_slave_byte_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_slave_byte_ctrl_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(spi_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_slave_byte_ctrl_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_slave_byte_ctrl_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(spi_mosi),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rx_shift_q, tx_shift_q, hold_data_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              hold_full_q, hold_full_d;

  logic              start, abort, in_frame, do_rise, do_fall;
  logic              tx_load, byte_done, tx_accept, rx_consume;
  logic [DATA_W-1:0] rx_word;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:   if (cs_fall) state_d = ACTIVE;
      ACTIVE: if (cs_rise) state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy        = (state_q == ACTIVE);
    spi_miso_oe = (state_q == ACTIVE);
  end

  assign spi_miso = tx_shift_q[DATA_W-1];

  // A CS_N rise masks any SCLK edge in the same cycle.
  always_comb begin
    start       = (state_q == IDLE) & cs_fall;
    abort       = (state_q == ACTIVE) & cs_rise;
    in_frame    = (state_q == ACTIVE) & ~cs_rise;
    do_rise     = in_frame & sclk_rise;
    do_fall     = in_frame & sclk_fall;
    tx_load     = start | (do_fall & (bit_cnt_q == '0));
    byte_done   = do_rise & (bit_cnt_q == CNT_W'(DATA_W - 1));
    tx_accept   = tx_valid & tx_ready;
    rx_consume  = rx_valid & rx_ready;
    rx_word     = {rx_shift_q[DATA_W-2:0], mosi_s};
    // An accepted byte beats a simultaneous shifter load.
    hold_full_d = hold_full_q;
    if (tx_accept)    hold_full_d = 1'b1;
    else if (tx_load) hold_full_d = 1'b0;
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      tx_ready    <= 1'b1;
    end else begin
      rx_overrun  <= byte_done & rx_valid & ~rx_ready;
      tx_underrun <= tx_load & ~hold_full_q;

      if (byte_done) begin
        rx_data  <= rx_word;
        rx_valid <= 1'b1;
      end else if (rx_consume) begin
        rx_valid <= 1'b0;
      end

      if (abort) begin
        bit_cnt_q  <= '0;
        rx_shift_q <= '0;
      end else if (start) begin
        bit_cnt_q  <= '0;
      end else if (do_rise) begin
        rx_shift_q <= rx_word;
        bit_cnt_q  <= byte_done ? '0 : bit_cnt_q + CNT_W'(1);
      end

      if (tx_load)      tx_shift_q <= hold_full_q ? hold_data_q : '0;
      else if (do_fall) tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};

      if (tx_accept) hold_data_q <= tx_data;
      hold_full_q <= hold_full_d;
      tx_ready    <= ~hold_full_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_byte_ctrl.sv
// Directed bench for spi_slave_byte_ctrl: a table of single-byte frames plus
// hand-written multi-byte, underrun/overrun, abort and collision sequences.
module tb_spi_slave_byte_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       rx_overrun, tx_underrun, busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int ovr_cnt = 0;
  int unf_cnt = 0;

  always #5 clk = ~clk;

  spi_slave_byte_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .busy(busy)
  );

  always @(negedge clk) begin
    if (rx_overrun)  ovr_cnt++;
    if (tx_underrun) unf_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] tx;
    logic       preload;
    logic [7:0] mosi;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_unf;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host_write(input logic [7:0] d);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 40) begin
      tick(1);
      n++;
    end
    if (n >= 40) check("host_write_timeout", 32'(tx_ready), 32'(1));
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(1);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(6);
  endtask

  // Mode-0 master: MOSI set while SCLK low, MISO sampled at the SCLK rise.
  // end_frame raises CS_N together with the final SCLK fall.
  // ready_pulse raises rx_ready for exactly the cycle the last bit lands.
  task automatic send_bits(input logic [7:0] m, input int nbits, input bit end_frame,
                           input bit ready_pulse, output logic [7:0] so);
    so = '0;
    for (int k = 0; k < nbits; k++) begin
      int i;
      i = 7 - k;
      spi_mosi = m[i];
      tick(4);
      spi_sclk = 1'b1;
      so[i] = spi_miso;
      if (ready_pulse && k == nbits - 1) begin
        tick(2);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
      end else begin
        tick(4);
      end
      spi_sclk = 1'b0;
      if (end_frame && k == nbits - 1) spi_cs_n = 1'b1;
    end
    tick(6);
  endtask

  initial begin
    logic [7:0] so, so1, so2;
    int base_u, base_o;

    vecs[0] = '{tx: 8'hA5, preload: 1'b1, mosi: 8'h3C, exp_rx: 8'h3C, exp_miso: 8'hA5, exp_unf: 0};
    vecs[1] = '{tx: 8'h00, preload: 1'b1, mosi: 8'hFF, exp_rx: 8'hFF, exp_miso: 8'h00, exp_unf: 0};
    vecs[2] = '{tx: 8'hFF, preload: 1'b1, mosi: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF, exp_unf: 0};
    vecs[3] = '{tx: 8'h77, preload: 1'b0, mosi: 8'h81, exp_rx: 8'h81, exp_miso: 8'h00, exp_unf: 1};
    vecs[4] = '{tx: 8'h5A, preload: 1'b1, mosi: 8'hC3, exp_rx: 8'hC3, exp_miso: 8'h5A, exp_unf: 0};

    // Reset with the pins toggling
    rst_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      spi_sclk = ~spi_sclk;
      spi_cs_n = ~spi_cs_n;
      spi_mosi = ~spi_mosi;
    end
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_miso", 32'(spi_miso), 32'(0));
    check("rst_miso_oe", 32'(spi_miso_oe), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rx_valid", 32'(rx_valid), 32'(0));
    spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    check("post_rst_busy", 32'(busy), 32'(0));
    check("post_rst_tx_ready", 32'(tx_ready), 32'(1));

    // Single-byte frames from the table
    foreach (vecs[v]) begin
      base_u = unf_cnt;
      base_o = ovr_cnt;
      if (vecs[v].preload) host_write(vecs[v].tx);
      cs_low();
      check("frame_busy", 32'(busy), 32'(1));
      send_bits(vecs[v].mosi, 8, 1'b1, 1'b0, so);
      check("frame_rx_data", 32'(rx_data), 32'(vecs[v].exp_rx));
      check("frame_rx_valid", 32'(rx_valid), 32'(1));
      check("frame_miso", 32'(so), 32'(vecs[v].exp_miso));
      check("frame_underruns", 32'(unf_cnt - base_u), 32'(vecs[v].exp_unf));
      check("frame_overruns", 32'(ovr_cnt - base_o), 32'(0));
      check("frame_tx_ready", 32'(tx_ready), 32'(1));
      check("frame_end_busy", 32'(busy), 32'(0));
      consume();
      check("frame_rx_consumed", 32'(rx_valid), 32'(0));
    end

    // Back-to-back bytes in one frame, holding register refilled mid-byte
    base_u = unf_cnt;
    host_write(8'h11);
    cs_low();
    check("b2b_tx_ready_after_load", 32'(tx_ready), 32'(1));
    host_write(8'h22);
    send_bits(8'h80, 8, 1'b0, 1'b0, so1);
    check("b2b_rx0", 32'(rx_data), 32'(8'h80));
    check("b2b_rx0_valid", 32'(rx_valid), 32'(1));
    consume();
    send_bits(8'h01, 8, 1'b1, 1'b0, so2);
    check("b2b_rx1", 32'(rx_data), 32'(8'h01));
    check("b2b_miso0", 32'(so1), 32'(8'h11));
    check("b2b_miso1", 32'(so2), 32'(8'h22));
    check("b2b_underruns", 32'(unf_cnt - base_u), 32'(0));
    consume();

    // Underrun and overrun
    base_u = unf_cnt;
    base_o = ovr_cnt;
    cs_low();
    send_bits(8'hFF, 8, 1'b0, 1'b0, so1);
    send_bits(8'h55, 8, 1'b1, 1'b0, so2);
    check("uo_miso0", 32'(so1), 32'(8'h00));
    check("uo_miso1", 32'(so2), 32'(8'h00));
    check("uo_underruns", 32'(unf_cnt - base_u), 32'(2));
    check("uo_overruns", 32'(ovr_cnt - base_o), 32'(1));
    check("uo_rx_data", 32'(rx_data), 32'(8'h55));
    check("uo_rx_valid", 32'(rx_valid), 32'(1));
    consume();

    // Abort after 5 SCLK rises, then a clean frame
    cs_low();
    send_bits(8'hB7, 5, 1'b0, 1'b0, so);
    spi_cs_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      if (!busy && !spi_miso_oe) break;
    end
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_miso_oe", 32'(spi_miso_oe), 32'(0));
    tick(8);
    check("abort_rx_valid", 32'(rx_valid), 32'(0));
    host_write(8'h69);
    cs_low();
    send_bits(8'h96, 8, 1'b1, 1'b0, so);
    check("after_abort_rx", 32'(rx_data), 32'(8'h96));
    check("after_abort_valid", 32'(rx_valid), 32'(1));
    check("after_abort_miso", 32'(so), 32'(8'h69));

    // Consume coinciding with completion (0x96 still pending)
    base_o = ovr_cnt;
    cs_low();
    send_bits(8'hE7, 8, 1'b1, 1'b1, so);
    check("coinc_rx_valid", 32'(rx_valid), 32'(1));
    check("coinc_rx_data", 32'(rx_data), 32'(8'hE7));
    check("coinc_overruns", 32'(ovr_cnt - base_o), 32'(0));

    // Reset mid-frame with the holding register full
    host_write(8'hF0);
    cs_low();
    host_write(8'h0F);
    check("midrst_pre_tx_ready", 32'(tx_ready), 32'(0));
    send_bits(8'hAA, 3, 1'b0, 1'b0, so);
    check("midrst_pre_busy", 32'(busy), 32'(1));
    check("midrst_pre_miso", 32'(spi_miso), 32'(1));
    rst_n = 1'b0;
    tick(1);
    check("midrst_tx_ready", 32'(tx_ready), 32'(1));
    check("midrst_rx_valid", 32'(rx_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_miso_oe", 32'(spi_miso_oe), 32'(0));
    check("midrst_miso", 32'(spi_miso), 32'(0));
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check("midrst_recover_busy", 32'(busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
